// File: rtl/msg_encrypt_engine.sv
// msg_encrypt_engine: pads, LFSR-encrypts and parity-tags a 61-byte message into a 64-byte ciphertext frame
module msg_encrypt_engine #(
    parameter logic [7:0] MSG_BASE  = 8'd0,
    parameter logic [7:0] CFG_PRE   = 8'd61,
    parameter logic [7:0] CFG_TAP   = 8'd62,
    parameter logic [7:0] CFG_SEED  = 8'd63,
    parameter logic [7:0] OUT_BASE  = 8'd64,
    parameter int         FRAME_LEN = 64,
    parameter logic [7:0] PRE_MIN   = 8'd10,
    parameter logic [7:0] PRE_MAX   = 8'd15,
    parameter logic [7:0] ASCII_OFS = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data
);
    typedef enum logic [2:0] {IDLE, LD_PRE, LD_TAP, LD_SEED, RD, WR, DONE} state_t;
    localparam logic [5:0] LAST = 6'(FRAME_LEN - 1);
    state_t     state, state_n;
    logic       start_q;
    logic [5:0] idx;
    logic [7:0] pre;
    logic [6:0] taps;
    logic [6:0] lfsr;
    logic [7:0] plain;
    logic       launch;
    logic       pad;
    logic       pad_next;
    logic [7:0] c;
    assign launch   = start_q & ~start;
    assign pad      = {2'b00, idx} < pre;
    assign pad_next = {2'b00, idx + 6'd1} < pre;
    assign c        = (pad ? 8'h00 : plain) ^ {1'b0, lfsr};
    // State register plus the config, key-stream and plaintext latches
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            idx     <= '0;
            pre     <= '0;
            taps    <= '0;
            lfsr    <= '0;
            plain   <= '0;
        end else begin
            start_q <= start;
            state   <= state_n;
            case (state)
                LD_PRE: begin
                    pre <= mem_rd_data < PRE_MIN ? PRE_MIN : mem_rd_data > PRE_MAX ? PRE_MAX : mem_rd_data;
                    idx <= '0;
                end
                LD_TAP:  taps  <= mem_rd_data[6:0];
                LD_SEED: lfsr  <= mem_rd_data[6:0] == 7'd0 ? 7'h01 : mem_rd_data[6:0];
                RD:      plain <= mem_rd_data - ASCII_OFS;
                WR: begin
                    lfsr <= {lfsr[5:0], ^(lfsr & taps)};
                    idx  <= idx + 6'd1;
                end
                default: ;
            endcase
        end
    end
    // Next state and memory-port drive; preamble slots skip the read cycle
    always_comb begin
        state_n     = state;
        ack         = 1'b0;
        mem_addr    = 8'h00;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        case (state)
            IDLE: state_n = launch ? LD_PRE : IDLE;
            LD_PRE: begin
                mem_addr = CFG_PRE;
                state_n  = LD_TAP;
            end
            LD_TAP: begin
                mem_addr = CFG_TAP;
                state_n  = LD_SEED;
            end
            LD_SEED: begin
                mem_addr = CFG_SEED;
                state_n  = pad ? WR : RD;
            end
            RD: begin
                mem_addr = MSG_BASE + ({2'b00, idx} - pre);
                state_n  = WR;
            end
            WR: begin
                mem_addr    = OUT_BASE + {2'b00, idx};
                mem_wr_en   = 1'b1;
                mem_wr_data = {^c[6:0], c[6:0]};
                state_n     = idx == LAST ? DONE : pad_next ? WR : RD;
            end
            DONE: begin
                ack     = 1'b1;
                state_n = launch ? LD_PRE : DONE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_msg_encrypt_engine.sv
// tb_msg_encrypt_engine: directed and randomized frame checks against a behavioural encryption model
module tb_msg_encrypt_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] dm [256];
    logic [7:0] exp_frame [64];
    int         exp_cyc;
    int         wr_cnt = 0;
    int         low_wr = 0;
    int         checks = 0;
    int         errors = 0;

    msg_encrypt_engine dut (
        .clk(clk), .reset(reset), .start(start), .ack(ack),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    always #5 clk = ~clk;
    assign mem_rd_data = dm[mem_addr];

    // Single-port memory: combinational read, write on rising edge
    always @(posedge clk) begin
        if (mem_wr_en) begin
            dm[mem_addr] = mem_wr_data;
            wr_cnt = wr_cnt + 1;
            if (mem_addr < 8'd64) low_wr = low_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plaintext stream (zeros for preamble, ASCII-0x20 afterwards) XOR key stream, parity in bit 7
    task automatic build_expected();
        int p;
        logic [6:0] key;
        logic [6:0] t;
        logic [7:0] pt;
        logic [6:0] cc;
        p = dm[61] < 10 ? 10 : (dm[61] > 15 ? 15 : int'(dm[61]));
        key = dm[63][6:0] == 7'd0 ? 7'd1 : dm[63][6:0];
        t = dm[62][6:0];
        for (int i = 0; i < 64; i++) begin
            pt = i < p ? 8'h00 : dm[i - p] - 8'h20;
            cc = pt[6:0] ^ key;
            exp_frame[i] = {1'($countones(cc) % 2), cc};
            key = {key[5:0], 1'($countones(key & t) % 2)};
        end
        exp_cyc = 3 + p + 2 * (64 - p) + 1;
    endtask

    task automatic setup(input logic [7:0] pre_b, input logic [7:0] tap_b, input logic [7:0] seed_b);
        for (int i = 0; i < 61; i++) dm[i] = 8'h20;
        for (int i = 64; i < 128; i++) dm[i] = 8'hEE;
        dm[61] = pre_b;
        dm[62] = tap_b;
        dm[63] = seed_b;
    endtask

    task automatic wait_ack(output int cyc);
        cyc = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic run_frame(input string tag);
        int cyc;
        int w0;
        build_expected();
        w0 = wr_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_ack(cyc);
        chk({tag, "_latency"}, cyc, exp_cyc);
        chk({tag, "_writes"}, wr_cnt - w0, 64);
        chk({tag, "_low_writes"}, low_wr, 0);
        for (int i = 0; i < 64; i++) begin
            chk({tag, "_byte"}, dm[64 + i], exp_frame[i]);
            chk({tag, "_parity"}, $countones(dm[64 + i]) % 2, 0);
        end
    endtask

    initial begin
        logic [7:0] s1 [7];
        logic [7:0] tap_tab [9];
        int cyc;
        int w0;
        s1 = '{8'h81, 8'h82, 8'h84, 8'h88, 8'h90, 8'hA0, 8'h41};
        tap_tab = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};
        for (int i = 0; i < 256; i++) dm[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_wren", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wr_data, 0);
        reset = 1'b0;
        @(negedge clk);

        setup(8'd10, 8'h60, 8'h01);
        run_frame("s1");
        for (int i = 0; i < 7; i++) chk("s1_const", dm[64 + i], s1[i]);

        w0 = wr_cnt;
        @(negedge clk) start = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_ack", ack, 1);
        chk("hold_writes", wr_cnt - w0, 0);
        start = 1'b0;
        wait_ack(cyc);
        chk("hold_release_latency", cyc, 122);

        setup(8'd10, 8'h60, 8'h01);
        dm[0] = 8'h4B;
        run_frame("s2");
        chk("s2_byte74", dm[74], 8'h33);
        chk("s2_byte73", dm[73], 8'h0C);

        setup(8'd10, 8'h60, 8'h00);
        run_frame("s3");
        for (int i = 0; i < 7; i++) chk("s3_const", dm[64 + i], s1[i]);

        setup(8'd3, 8'h60, 8'h01);
        run_frame("s4a");
        for (int i = 0; i < 7; i++) chk("s4a_const", dm[64 + i], s1[i]);
        setup(8'h1F, 8'h60, 8'h01);
        dm[0] = 8'h4B;
        run_frame("s4b");
        chk("s4b_cycles", exp_cyc, 117);

        setup(8'd10, 8'h60, 8'h01);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("midrst_ack", ack, 0);
        chk("midrst_wren", mem_wr_en, 0);
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        chk("midrst_writes", wr_cnt - w0, 0);
        chk("midrst_ack_idle", ack, 0);
        run_frame("s5");

        @(negedge clk) start = 1'b1;
        @(negedge clk) begin
            start = 1'b0;
            reset = 1'b1;
        end
        @(negedge clk) reset = 1'b0;
        w0 = wr_cnt;
        repeat (10) @(negedge clk);
        chk("rst_wins_ack", ack, 0);
        chk("rst_wins_addr", mem_addr, 0);
        chk("rst_wins_writes", wr_cnt - w0, 0);

        for (int t = 0; t < 9; t++) begin
            setup(8'($urandom_range(0, 255)), tap_tab[t], 8'($urandom_range(0, 255)));
            for (int i = 0; i < 52; i++) dm[i] = 8'($urandom_range(8'h20, 8'h7E));
            if (t == 4) dm[3] = 8'h0A;
            run_frame("s6");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
